// File: rtl/core_ifu.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit, buffers
// responses and hands {pc, instr} to decode. Define CORE_IFU_BYPASS_EN for same-cycle response bypass.
`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 32
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif

module core_ifu #(
    parameter logic [`CPU_PC_SIZE-1:0] RESET_PC   = '0,
    parameter int                      FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid_o,
    input  logic                       imem_req_ready_i,
    output logic [`CPU_PC_SIZE-1:0]    imem_req_addr_o,
    input  logic                       imem_rsp_valid_i,
    input  logic [`CPU_INSTR_SIZE-1:0] imem_rsp_data_i,
    input  logic                       redirect_i,
    input  logic [`CPU_PC_SIZE-1:0]    redirect_pc_i,
    output logic                       ifu_valid_o,
    input  logic                       idu_ready_i,
    output logic [`CPU_PC_SIZE-1:0]    pc_o,
    output logic [`CPU_INSTR_SIZE-1:0] instr_o
);
    localparam int PCW = `CPU_PC_SIZE;
    localparam int IW  = `CPU_INSTR_SIZE;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PCW-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;

    // PC FIFO: address of every accepted request, popped as its response returns.
    logic [PCW-1:0]  pcq_mem [FIFO_DEPTH];
    logic [PW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

    logic [PCW-1:0]  ib_pc_mem    [FIFO_DEPTH];
    logic [IW-1:0]   ib_instr_mem [FIFO_DEPTH];
    logic [PW-1:0]   ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
    logic [CW-1:0]   ib_cnt_q, ib_cnt_d;

    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_live;
    logic            ib_nonempty;
    logic            byp_active;
    logic            ib_push;
    logic            ib_pop;
    logic [PCW-1:0]  pcq_head;

    assign occupancy        = {1'b0, inflight_q} + {1'b0, ib_cnt_q};
    assign credit_ok        = occupancy < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid_o = !rst && (state_q == ST_FETCH) && !redirect_i && credit_ok;
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_live         = imem_rsp_valid_i && (state_q == ST_FETCH) && !redirect_i;
    assign ib_nonempty      = (ib_cnt_q != '0);
    assign pcq_head         = pcq_mem[pcq_rd_q];

`ifdef CORE_IFU_BYPASS_EN
    assign byp_active = rsp_live && !ib_nonempty;
`else
    assign byp_active = 1'b0;
`endif

    assign ifu_valid_o = !redirect_i && (ib_nonempty || byp_active);
    assign ib_pop      = ib_nonempty && idu_ready_i && !redirect_i;
    // A bypassed response that decode takes immediately never occupies the buffer.
    assign ib_push     = rsp_live && !(byp_active && idu_ready_i);

    always_comb begin
        pc_o    = '0;
        instr_o = '0;
        if (ifu_valid_o) begin
            if (ib_nonempty) begin
                pc_o    = ib_pc_mem[ib_rd_q];
                instr_o = ib_instr_mem[ib_rd_q];
            end else begin
                pc_o    = pcq_head;
                instr_o = imem_rsp_data_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        ib_wr_d    = ib_wr_q;
        ib_rd_d    = ib_rd_q;
        ib_cnt_d   = ib_cnt_q + CW'(ib_push) - CW'(ib_pop);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PCW'(4);
            pcq_wr_d   = pcq_wr_q + PW'(1);
        end
        if (rsp_live) pcq_rd_d = pcq_rd_q + PW'(1);
        if (ib_push)  ib_wr_d  = ib_wr_q + PW'(1);
        if (ib_pop)   ib_rd_d  = ib_rd_q + PW'(1);

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            ib_wr_d    = '0;
            ib_rd_d    = '0;
            ib_cnt_d   = '0;
        end

        case (state_q)
            ST_FETCH: if (redirect_i && inflight_d != '0) state_d = ST_FLUSH;
            ST_FLUSH: if (inflight_d == '0) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
            ib_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            ib_wr_q    <= ib_wr_d;
            ib_rd_q    <= ib_rd_d;
            ib_cnt_q   <= ib_cnt_d;
        end
    end

    // Storage arrays carry no reset; occupancy pointers alone define their contents.
    always_ff @(posedge clk) begin
        if (req_fire) pcq_mem[pcq_wr_q] <= imem_req_addr_o;
        if (ib_push) begin
            ib_pc_mem[ib_wr_q]    <= pcq_head;
            ib_instr_mem[ib_wr_q] <= imem_rsp_data_i;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) assert (!(imem_rsp_valid_i && inflight_q == '0));
    end
`endif

endmodule
